// File: rtl/hash_byte_serializer_pkg.sv
// Shared widths and types for the hash byte serializer slice.
package hash_pkg;

    localparam int HASH_W         = 128;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_HASH = HASH_W / BYTE_W;
    localparam int BCNT_W         = $clog2(BYTES_PER_HASH);

    typedef logic [HASH_W-1:0] hash_t;
    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic {S_IDLE, S_SEND} ser_state_e;

endpackage

// File: rtl/hash_byte_serializer_if.sv
// Hash input, byte stream output and status signals of the serializer.
// The slave modport is the serializer; the master modport is whoever feeds/drains it.
interface hash_byte_serializer_if #(
    parameter int DEPTH = 4
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    hash_pkg::hash_t  hash_i;
    logic             hash_valid_i;
    hash_pkg::byte_t  byte_o;
    logic             byte_valid_o;
    logic             byte_ready_i;
    logic [CNT_W-1:0] level_o;
    logic             busy_o;
    logic             overflow_o;

    modport slave (
        input  hash_i, hash_valid_i, byte_ready_i,
        output byte_o, byte_valid_o, level_o, busy_o, overflow_o
    );

    modport master (
        output hash_i, hash_valid_i, byte_ready_i,
        input  byte_o, byte_valid_o, level_o, busy_o, overflow_o
    );
endinterface

// File: rtl/hash_byte_serializer_fifo.sv
// Small register-array FIFO holding finished hashes until the shifter takes them.
// Head entry is readable combinationally so a pop can load the shifter on the same edge.
module hash_fifo
    import hash_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  hash_t            push_data,
    input  logic             pop,
    output hash_t            pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level
);

    hash_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] level_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level_reg == CNT_W'(DEPTH));
    assign empty    = (level_reg == '0);
    assign level    = level_reg;
    assign pop_data = mem[rd_ptr_reg];

    // Guard against misuse so the pointers can never run past each other.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage write; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and fill level; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + CNT_W'(1);
                2'b01:   level_reg <= level_reg - CNT_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/hash_byte_serializer.sv
// Buffers finished 128-bit hashes and sends each one MSB byte first on a
// valid/ready byte stream. Hashes arriving while the buffer is full are dropped
// and a sticky overflow flag is raised.
module hash_byte_serializer
    import hash_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hash_byte_serializer_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    ser_state_e        state_reg, state_next;
    hash_t             shreg_reg, shreg_next;
    logic [BCNT_W-1:0] cnt_reg, cnt_next;
    logic              overflow_reg;

    logic              fifo_push;
    logic              fifo_pop;
    hash_t             fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_level;
    logic              handshake;
    logic              last_byte;

    // The full test uses the pre-edge level, so a same-edge pop never rescues a hash.
    assign fifo_push = bus.hash_valid_i && !fifo_full;

    hash_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (bus.hash_i),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign handshake = (state_reg == S_SEND) && bus.byte_ready_i;
    assign last_byte = (cnt_reg == BCNT_W'(BYTES_PER_HASH - 1));

    // Next-state logic: load the shifter from the FIFO head, shift on each accepted byte,
    // and chain straight into the next hash after the 16th byte when one is waiting.
    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        cnt_next   = cnt_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shreg_next = fifo_head;
                    cnt_next   = '0;
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (handshake) begin
                    if (last_byte) begin
                        cnt_next = '0;
                        if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            shreg_next = fifo_head;
                        end else begin
                            shreg_next = shreg_reg << BYTE_W;
                            state_next = S_IDLE;
                        end
                    end else begin
                        shreg_next = shreg_reg << BYTE_W;
                        cnt_next   = cnt_reg + BCNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, shifter and byte counter registers; reset discards any hash in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (bus.hash_valid_i && fifo_full) begin
            overflow_reg <= 1'b1;
        end
    end

    assign bus.byte_o       = shreg_reg[HASH_W-1 -: BYTE_W];
    assign bus.byte_valid_o = (state_reg == S_SEND);
    assign bus.busy_o       = (state_reg == S_SEND);
    assign bus.level_o      = fifo_level;
    assign bus.overflow_o   = overflow_reg;

endmodule

// File: tb/tb_hash_byte_serializer.sv
// Directed bench for hash_byte_serializer: reset, single hash, backpressure,
// back-to-back hashes, overflow and asynchronous reset mid-hash.
module tb_hash_byte_serializer;
    import hash_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hash_byte_serializer_if #(.DEPTH(4)) bus ();

    hash_byte_serializer #(
        .DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam hash_t H_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam hash_t H_B = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
    localparam hash_t H_C = 128'h13579BDF_02468ACE_FEDCBA98_76543210;

    hash_t ov_h [6];

    function automatic byte_t byte_of(input hash_t h, input int idx);
        hash_t t;
        t = h >> (8 * (15 - idx));
        return t[7:0];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input hash_t h);
        bus.hash_i       = h;
        bus.hash_valid_i = 1'b1;
        step();
        bus.hash_valid_i = 1'b0;
        $display("hash pulse %032h level=%0d overflow=%0b", h, bus.level_o, bus.overflow_o);
    endtask

    // Check all 16 bytes of h with ready high, optionally stalling 5 cycles at byte stall_at.
    task automatic stream(input string tag, input hash_t h, input int stall_at);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_valid"}, 128'(bus.byte_valid_o), 128'(1'b1));
            chk({tag, "_byte"}, 128'(bus.byte_o), 128'(byte_of(h, i)));
            if (i == stall_at) begin
                bus.byte_ready_i = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    chk({tag, "_hold_byte"}, 128'(bus.byte_o), 128'(byte_of(h, i)));
                    chk({tag, "_hold_valid"}, 128'(bus.byte_valid_o), 128'(1'b1));
                end
                bus.byte_ready_i = 1'b1;
            end
            step();
        end
        $display("hash streamed %032h (%s)", h, tag);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid0"}, 128'(bus.byte_valid_o), 128'(1'b0));
        chk({tag, "_busy0"}, 128'(bus.busy_o), 128'(1'b0));
        chk({tag, "_level0"}, 128'(bus.level_o), 128'(0));
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            ov_h[i] = {8'(8'hA0 + i), 8'h01, 112'h0203_0405_0607_0809_0A0B_0C0D_0E0F} ^ {16{8'(i)}};
        end
        rst_n            = 1'b0;
        bus.hash_i       = '0;
        bus.hash_valid_i = 1'b0;
        bus.byte_ready_i = 1'b0;

        // 1: reset held, a pulse must not be written
        step();
        pulse(H_A);
        chk_idle("rst_hold");
        chk("rst_byte", 128'(bus.byte_o), 128'(0));
        chk("rst_ovf", 128'(bus.overflow_o), 128'(0));
        rst_n = 1'b1;
        step();
        step();
        chk_idle("rst_release");

        // 2: single hash, ready high
        bus.byte_ready_i = 1'b1;
        pulse(H_A);
        chk("single_lat_valid0", 128'(bus.byte_valid_o), 128'(0));
        chk("single_lat_level1", 128'(bus.level_o), 128'(1));
        step();
        chk("single_lat_level0", 128'(bus.level_o), 128'(0));
        chk("single_busy", 128'(bus.busy_o), 128'(1));
        stream("single", H_A, -1);
        chk_idle("single_done");

        // 3: backpressure at byte 0x77 (index 7)
        pulse(H_A);
        step();
        stream("bp", H_A, 7);
        chk_idle("bp_done");

        // 4: three hashes on consecutive cycles
        pulse(H_A);
        chk("b2b_level_n0", 128'(bus.level_o), 128'(1));
        pulse(H_B);
        chk("b2b_level_n1", 128'(bus.level_o), 128'(1));
        chk("b2b_first_byte", 128'(bus.byte_o), 128'(byte_of(H_A, 0)));
        pulse(H_C);
        chk("b2b_level_peak", 128'(bus.level_o), 128'(2));
        chk("b2b_second_byte", 128'(bus.byte_o), 128'(byte_of(H_A, 1)));
        step();
        for (int k = 2; k < 48; k++) begin
            hash_t cur;
            cur = (k < 16) ? H_A : ((k < 32) ? H_B : H_C);
            chk("b2b_valid", 128'(bus.byte_valid_o), 128'(1));
            chk("b2b_byte", 128'(bus.byte_o), 128'(byte_of(cur, k % 16)));
            step();
        end
        chk_idle("b2b_done");

        // 5: overflow with the sink stalled
        bus.byte_ready_i = 1'b0;
        pulse(ov_h[0]);
        chk("ovf_level_p0", 128'(bus.level_o), 128'(1));
        pulse(ov_h[1]);
        chk("ovf_level_p1", 128'(bus.level_o), 128'(1));
        pulse(ov_h[2]);
        chk("ovf_level_p2", 128'(bus.level_o), 128'(2));
        pulse(ov_h[3]);
        chk("ovf_level_p3", 128'(bus.level_o), 128'(3));
        pulse(ov_h[4]);
        chk("ovf_level_p4", 128'(bus.level_o), 128'(4));
        chk("ovf_flag_clear", 128'(bus.overflow_o), 128'(0));
        pulse(ov_h[5]);
        chk("ovf_level_p5", 128'(bus.level_o), 128'(4));
        chk("ovf_flag_set", 128'(bus.overflow_o), 128'(1));
        chk("ovf_busy", 128'(bus.busy_o), 128'(1));
        bus.byte_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            stream("ovf_drain", ov_h[i], -1);
        end
        chk_idle("ovf_done");
        chk("ovf_sticky", 128'(bus.overflow_o), 128'(1));
        step();
        chk("ovf_no_sixth", 128'(bus.byte_valid_o), 128'(0));

        // 6: asynchronous reset while byte index 8 is on the bus
        rst_n = 1'b0;
        #1;
        chk("ovf_cleared", 128'(bus.overflow_o), 128'(0));
        rst_n = 1'b1;
        step();
        pulse(H_B);
        step();
        for (int i = 0; i < 8; i++) begin
            chk("arst_pre_byte", 128'(bus.byte_o), 128'(byte_of(H_B, i)));
            step();
        end
        chk("arst_byte8", 128'(bus.byte_o), 128'(byte_of(H_B, 8)));
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("arst_now");
        chk("arst_byte0", 128'(bus.byte_o), 128'(0));
        step();
        rst_n = 1'b1;
        step();
        chk_idle("arst_after");
        pulse(H_C);
        step();
        stream("arst_next", H_C, -1);
        chk_idle("arst_next_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
